instr_prefetch_buf: RTL and testbench

- Fetch-side instruction prefetch buffer that sits between the instruction cache and the ID stage.
- Generates sequential fetch PCs and issues requests to the instruction cache.
- Queues returned instructions with their PCs and presents them to ID through a valid/ready handshake.
- A branch or jump resolved downstream redirects it: queued entries are flushed and stale in-flight responses are discarded.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/instr_prefetch_buf.sv | 140 ++++++++++++++
 tb/tb_instr_prefetch_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    // log2 of the instruction size in bytes; PCs step by 1 << INSTR_ALIGN
    localparam int unsigned INSTR_ALIGN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; head is read straight from registered storage.
// Latency: an entry pushed at edge N is visible on data_o after edge N.
// Backpressure: push at full is legal only together with pop; producers must respect full_o.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A full FIFO may still accept a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    overflow_chk:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(push_i && full_o && !pop_i && !clear_i));
    underflow_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(pop_i && empty_o && !clear_i));

endmodule

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetcher between I-cache and ID, with redirect flush.
// Latency: response at edge N+k is presented to ID from edge N+k+1; 1 instr/cycle sustained.
// Backpressure: requests stop while queued+outstanding reaches DEPTH; ID stalls via id_ready_i.
module instr_prefetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_gnt_i,
    input  logic        icache_rvalid_i,
    input  logic [31:0] icache_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i
);

    localparam int unsigned CW         = $clog2(DEPTH + 1);
    localparam logic [31:0] PC_STEP    = 32'd1 << INSTR_ALIGN;
    localparam logic [31:0] ALIGN_MASK = ~(PC_STEP - 32'd1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    fetch_entry_t  last_q;

    logic          fire, accept_rsp, pop;
    logic [CW:0]   credit_used;
    logic [31:0]   pcq_head;
    logic          pcq_full, pcq_empty;
    logic [CW-1:0] pcq_count;
    fetch_entry_t  iq_in, iq_head;
    logic          iq_full, iq_empty;
    logic [CW-1:0] iq_count;

    // Credit uses registered occupancy only, so a same-cycle pop frees nothing until next cycle.
    assign credit_used   = {1'b0, iq_count} + {1'b0, outstanding_q};
    assign icache_req_o  = (state_q != IDLE) && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign icache_addr_o = fetch_pc_q;
    assign fire          = icache_req_o && icache_gnt_i;

    // Responses are kept only when nothing stale is still in flight and no redirect is happening.
    assign accept_rsp = icache_rvalid_i && (drop_q == '0) && !redirect_i;
    assign pop        = id_valid_o && id_ready_i;
    assign iq_in      = '{pc: pcq_head, instr: icache_rdata_i};

    // PCs of live requests, matched to responses in order.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (redirect_i),
        .push_i  (fire),
        .data_i  (fetch_pc_q),
        .pop_i   (accept_rsp),
        .data_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    // Returned instructions awaiting ID.
    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (redirect_i),
        .push_i  (accept_rsp),
        .data_i  (iq_in),
        .pop_i   (pop),
        .data_o  (iq_head),
        .full_o  (iq_full),
        .empty_o (iq_empty),
        .count_o (iq_count)
    );

    assign id_valid_o = !iq_empty;
    assign id_pc_o    = id_valid_o ? iq_head.pc    : last_q.pc;
    assign id_instr_o = id_valid_o ? iq_head.instr : last_q.instr;

    // Next-state logic: fetch PC advance, in-flight accounting, flush bookkeeping; redirect wins.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(fire) - CW'(icache_rvalid_i);

        if (fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (icache_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            FLUSH:   if (drop_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        // Everything still in flight after this edge belongs to the old path.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ALIGN_MASK;
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Remember the last presented head so id_* hold their value while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         last_q <= '0;
        else if (id_valid_o) last_q <= iq_head;
    end

    pcq_track_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    pcq_count == outstanding_q - drop_q);
    pcq_room_chk:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(fire && pcq_full));
    pcq_rsp_chk:   assert property (@(posedge clk_i) disable iff (!rst_ni) !(accept_rsp && pcq_empty));
    iq_room_chk:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(accept_rsp && iq_full && !pop));

endmodule

// File: tb/tb_instr_prefetch_buf.sv
module tb_instr_prefetch_buf;

    logic        clk;
    logic        rst_ni, redirect_i, icache_gnt_i, icache_rvalid_i, id_ready_i;
    logic [31:0] redirect_pc_i, icache_rdata_i;
    logic        icache_req_o, id_valid_o;
    logic [31:0] icache_addr_o, id_instr_o, id_pc_o;

    // Second instance for the wrap-around reset PC
    logic        rst2_n, gnt2, rvalid2, ready2, redirect2;
    logic [31:0] rdata2, redirect_pc2;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2;

    instr_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o), .icache_gnt_i(icache_gnt_i),
        .icache_rvalid_i(icache_rvalid_i), .icache_rdata_i(icache_rdata_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
    );

    instr_prefetch_buf #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .icache_req_o(req2), .icache_addr_o(addr2), .icache_gnt_i(gnt2),
        .icache_rvalid_i(rvalid2), .icache_rdata_i(rdata2),
        .id_valid_o(valid2), .id_instr_o(instr2), .id_pc_o(pc2), .id_ready_i(ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] pc; int epoch; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    pend_t       pend[$];      // cache-side outstanding requests (in order)
    exp_t        exp_q[$];     // scoreboard: entries ID should see, in order
    logic [31:0] mdl_pc;       // next sequential fetch address per the model
    int          epoch, edges, cyc, pops;
    int          n_checks, n_fail;
    int          gnt_pct, rdy_pct, redir_pm, lat_min, lat_max;
    bit          collide_req;
    logic [31:0] got2_pc[$], got2_instr[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of random cache/ID/redirect stimulus just after the rising edge.
    task automatic step(input bit fr, input logic [31:0] fpc);
        @(posedge clk); #1;
        icache_gnt_i = ($urandom_range(99) < gnt_pct);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            icache_rvalid_i = 1'b1;
            icache_rdata_i  = mem(pend[0].addr);
        end else begin
            icache_rvalid_i = 1'b0;
            icache_rdata_i  = $urandom();
        end
        id_ready_i    = ($urandom_range(99) < rdy_pct);
        redirect_i    = fr || ($urandom_range(999) < redir_pm);
        redirect_pc_i = fr ? fpc : (($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                            : $urandom());
        if (collide_req && icache_rvalid_i) begin
            icache_gnt_i  = 1'b1;
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0200;
            collide_req   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni = 1'b0; icache_gnt_i = 0; icache_rvalid_i = 0; redirect_i = 0; id_ready_i = 0;
        #1;
        check("rst_req", icache_req_o, 0);
        check("rst_valid", id_valid_o, 0);
        check("rst_instr", id_instr_o, 0);
        check("rst_pc", id_pc_o, 0);
        check("rst_addr", icache_addr_o, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    // Reference model: cache bookkeeping plus epoch-tagged expected stream (after the monitor).
    initial forever begin
        pend_t p;
        @(negedge clk); #1;
        if (!rst_ni) begin
            pend.delete(); exp_q.delete();
            mdl_pc = 32'h0; edges = 0; epoch = 0;
        end else begin
            if (icache_rvalid_i && pend.size() != 0) begin
                p = pend.pop_front();
                if (!redirect_i && p.epoch == epoch) exp_q.push_back('{p.pc, mem(p.pc)});
            end
            if (icache_req_o && icache_gnt_i) begin
                pend.push_back('{icache_addr_o, mdl_pc, epoch, cyc + $urandom_range(lat_max, lat_min)});
                mdl_pc = mdl_pc + 32'd4;
            end
            if (redirect_i) begin
                epoch++;
                exp_q.delete();
                mdl_pc = redirect_pc_i & ~32'h3;
            end
            edges++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    initial forever begin
        logic er;
        exp_t e;
        @(negedge clk);
        if (rst_ni) begin
            er = (edges >= 1) && !redirect_i && ((exp_q.size() + pend.size()) < 4);
            check("icache_req", icache_req_o, er);
            if (er && icache_req_o) check("icache_addr", icache_addr_o, mdl_pc);
            check("id_valid", id_valid_o, exp_q.size() != 0);
            if (id_valid_o && id_ready_i && exp_q.size() != 0) begin
                pops++;
                e = exp_q.pop_front();
                check("id_pc", id_pc_o, e.pc);
                check("id_instr", id_instr_o, e.instr);
            end
        end
    end

    // Latency-1 always-granting cache and collector for the second instance.
    initial begin
        logic        f2;
        logic [31:0] a2;
        rvalid2 = 0; rdata2 = 0;
        forever begin
            @(negedge clk);
            f2 = req2 && rst2_n;
            a2 = addr2;
            if (rst2_n && valid2 && got2_pc.size() < 3) begin
                got2_pc.push_back(pc2);
                got2_instr.push_back(instr2);
            end
            @(posedge clk); #1;
            rvalid2 = f2;
            rdata2  = mem(a2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1);
    end

    initial begin
        bit          found;
        int          p0;
        logic [31:0] exp2 [3];
        n_checks = 0; n_fail = 0; pops = 0; cyc = 0; collide_req = 0;
        gnt_pct = 100; rdy_pct = 100; redir_pm = 0; lat_min = 1; lat_max = 1;
        rst_ni = 0; redirect_i = 0; redirect_pc_i = 0; icache_gnt_i = 0;
        icache_rvalid_i = 0; icache_rdata_i = 0; id_ready_i = 0;
        rst2_n = 0; gnt2 = 1; ready2 = 1; redirect2 = 0; redirect_pc2 = 0;

        // 1: streaming from reset, latency 1, ID always ready
        do_reset();
        rst2_n = 1'b1;
        repeat (12) step(0, 0);
        p0 = pops;
        repeat (20) step(0, 0);
        check("throughput", pops - p0, 20);

        // 2: ID stalled, queue fills to 4, then drains in order
        do_reset();
        rdy_pct = 0;
        repeat (15) step(0, 0);
        @(negedge clk);
        check("stall_req", icache_req_o, 0);
        check("stall_valid", id_valid_o, 1);
        check("stall_head_pc", id_pc_o, 32'h0);
        check("stall_head_instr", id_instr_o, mem(32'h0));
        rdy_pct = 100;
        repeat (12) step(0, 0);

        // 3: latency 3, redirect to an unaligned target
        lat_min = 3; lat_max = 3;
        repeat (8) step(0, 0);
        step(1, 32'h0000_0103);
        step(0, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (id_valid_o) found = 1;
            else step(0, 0);
        end
        check("redirect_found", found, 1);
        check("redirect_first_pc", id_pc_o, 32'h0000_0100);

        // 4: redirect coinciding with rvalid and gnt
        lat_min = 2; lat_max = 2;
        repeat (3) step(0, 0);
        collide_req = 1;
        for (int i = 0; i < 40 && collide_req; i++) step(0, 0);
        check("collide_seen", collide_req, 0);
        repeat (10) step(0, 0);

        // 6: reset with 3 queued and 1 outstanding
        do_reset();
        rdy_pct = 0; lat_min = 5; lat_max = 5;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0);
            if (exp_q.size() == 3 && pend.size() == 1) found = 1;
        end
        check("pre_reset_fill", found, 1);
        do_reset();
        rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) step(0, 0);

        // Random traffic
        gnt_pct = 70; rdy_pct = 60; redir_pm = 30; lat_min = 1; lat_max = 5;
        repeat (2000) step(0, 0);

        // Quiesce: no new grants, everything drains
        gnt_pct = 0; rdy_pct = 100; redir_pm = 0;
        repeat (20) step(0, 0);
        @(negedge clk);
        check("final_empty", id_valid_o, 0);

        // 5: wrap-around from RESET_PC 0xFFFF_FFF8
        exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC; exp2[2] = 32'h0000_0000;
        check("wrap_count", got2_pc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got2_pc.size()) begin
                check("wrap_pc", got2_pc[i], exp2[i]);
                check("wrap_instr", got2_instr[i], mem(exp2[i]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
